// File: rtl/ir_nec_pkg.sv
// rtl/ir_nec_pkg.sv - NEC receiver states, timing windows and helpers
package ir_nec_pkg;

  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] width_t;

  localparam width_t CNT_MAX          = 11'd2047;

  localparam width_t LEAD_MARK_MIN    = 11'd800;
  localparam width_t LEAD_MARK_MAX    = 11'd1000;
  localparam width_t LEAD_SPACE_F_MIN = 11'd400;
  localparam width_t LEAD_SPACE_F_MAX = 11'd500;
  localparam width_t LEAD_SPACE_R_MIN = 11'd200;
  localparam width_t LEAD_SPACE_R_MAX = 11'd250;
  localparam width_t BIT_MARK_MIN     = 11'd40;
  localparam width_t BIT_MARK_MAX     = 11'd75;
  localparam width_t SPACE_0_MIN      = 11'd40;
  localparam width_t SPACE_0_MAX      = 11'd75;
  localparam width_t SPACE_1_MIN      = 11'd140;
  localparam width_t SPACE_1_MAX      = 11'd190;
  localparam width_t TIMEOUT          = 11'd1300;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    RPT_MARK
  } state_t;

  function automatic logic in_win(width_t w, width_t lo, width_t hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_glitch_filter.sv
// rtl/ir_glitch_filter.sv - 2-FF synchronizer, stability filter and edge pulses
module ir_glitch_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall,
  output logic rise
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [FW-1:0] cnt;

  // Bring the asynchronous input into the clock domain; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      fall <= 1'b0;
      rise <= 1'b0;
      if (sync2 != level) begin
        if (cnt == FW'(FILTER_LEN - 1)) begin
          level <= sync2;
          cnt   <= '0;
          fall  <= ~sync2;
          rise  <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ir_nec_rx.sv
// rtl/ir_nec_rx.sv - NEC infrared frame and repeat-code decoder
module ir_nec_rx
  import ir_nec_pkg::*;
#(
  parameter int TICK_DIV   = 500,
  parameter int FILTER_LEN = 8
) (
  input  logic        csi_clk,
  input  logic        csi_reset,
  input  logic        coe_ir,
  output logic [31:0] frame_data,
  output logic        frame_valid,
  output logic        frame_repeat,
  output logic        frame_error
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic          fall;
  logic          rise;
  logic          tick;
  logic [PW-1:0] pre_cnt;
  width_t        width;

  state_t        state, state_n;
  logic [31:0]   shift, shift_n;
  logic [5:0]    bit_cnt, bit_cnt_n;
  logic [31:0]   data_n;
  logic          have_frame, have_n;
  logic          valid_n, rpt_n, err_n;
  logic          err;

  ir_glitch_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk (csi_clk),
    .rst (csi_reset),
    .din (coe_ir),
    .fall(fall),
    .rise(rise)
  );

  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  // Prescaler producing one timing tick every TICK_DIV clocks.
  always_ff @(posedge csi_clk) begin
    if (csi_reset || tick) pre_cnt <= '0;
    else                   pre_cnt <= pre_cnt + 1'b1;
  end

  // Width of the current mark or space in ticks, saturating, restarted at each edge.
  always_ff @(posedge csi_clk) begin
    if (csi_reset || fall || rise) width <= '0;
    else if (tick && width != CNT_MAX) width <= width + 1'b1;
  end

  // State and datapath registers; strobes are registered one-cycle pulses.
  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      state        <= IDLE;
      shift        <= '0;
      bit_cnt      <= '0;
      frame_data   <= '0;
      have_frame   <= 1'b0;
      frame_valid  <= 1'b0;
      frame_repeat <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      state        <= state_n;
      shift        <= shift_n;
      bit_cnt      <= bit_cnt_n;
      frame_data   <= data_n;
      have_frame   <= have_n;
      frame_valid  <= valid_n;
      frame_repeat <= rpt_n;
      frame_error  <= err_n;
    end
  end

  // Classify each measured width at the edge that ends it and walk the frame.
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    data_n    = frame_data;
    have_n    = have_frame;
    valid_n   = 1'b0;
    rpt_n     = 1'b0;
    err_n     = 1'b0;
    err       = 1'b0;

    case (state)
      IDLE: begin
        if (fall) state_n = LEAD_MARK;
      end
      LEAD_MARK: begin
        if (rise) begin
          if (in_win(width, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_n = LEAD_SPACE;
          else                                             err     = 1'b1;
        end
      end
      LEAD_SPACE: begin
        if (fall) begin
          if (in_win(width, LEAD_SPACE_F_MIN, LEAD_SPACE_F_MAX)) begin
            state_n   = BIT_MARK;
            bit_cnt_n = '0;
          end else if (in_win(width, LEAD_SPACE_R_MIN, LEAD_SPACE_R_MAX)) begin
            state_n = RPT_MARK;
          end else begin
            err = 1'b1;
          end
        end
      end
      BIT_MARK: begin
        if (rise) begin
          if (in_win(width, BIT_MARK_MIN, BIT_MARK_MAX)) state_n = BIT_SPACE;
          else                                           err     = 1'b1;
        end
      end
      BIT_SPACE: begin
        if (fall) begin
          if (in_win(width, SPACE_0_MIN, SPACE_0_MAX) ||
              in_win(width, SPACE_1_MIN, SPACE_1_MAX)) begin
            // Right shift so the first bit received ends up in bit 0.
            shift_n   = {in_win(width, SPACE_1_MIN, SPACE_1_MAX), shift[31:1]};
            bit_cnt_n = bit_cnt + 1'b1;
            state_n   = (bit_cnt_n == 6'd32) ? STOP_MARK : BIT_MARK;
          end else begin
            err = 1'b1;
          end
        end
      end
      STOP_MARK: begin
        if (rise) begin
          if (in_win(width, BIT_MARK_MIN, BIT_MARK_MAX) &&
              shift[31:24] == ~shift[23:16]) begin
            data_n  = shift;
            valid_n = 1'b1;
            have_n  = 1'b1;
            state_n = IDLE;
          end else begin
            err = 1'b1;
          end
        end
      end
      RPT_MARK: begin
        if (rise) begin
          if (in_win(width, BIT_MARK_MIN, BIT_MARK_MAX)) begin
            rpt_n   = have_frame;
            state_n = IDLE;
          end else begin
            err = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE && !fall && !rise && width == TIMEOUT) err = 1'b1;

    if (err) begin
      err_n   = 1'b1;
      have_n  = 1'b0;
      valid_n = 1'b0;
      rpt_n   = 1'b0;
      data_n  = frame_data;
      state_n = IDLE;
    end
  end

endmodule

// File: tb/tb_ir_nec_rx.sv
// tb/tb_ir_nec_rx.sv - scoreboard bench for the NEC infrared decoder
module tb_ir_nec_rx;

  localparam int TD = 1;
  localparam int FL = 8;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
  } ev_t;

  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_RPT   = 2'd1;
  localparam logic [1:0] K_ERR   = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir  = 1'b1;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        frame_repeat;
  logic        frame_error;

  ev_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_data   = '0;
  logic        m_have   = 1'b0;
  logic [1:0]  mon_kind;
  ev_t         mon_ev;

  ir_nec_rx #(
    .TICK_DIV  (TD),
    .FILTER_LEN(FL)
  ) dut (
    .csi_clk     (clk),
    .csi_reset   (rst),
    .coe_ir      (ir),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_repeat(frame_repeat),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (frame_valid || frame_repeat || frame_error) begin
      mon_kind = frame_valid ? K_VALID : (frame_repeat ? K_RPT : K_ERR);
      check("strobe_onehot", 32'($countones({frame_valid, frame_repeat, frame_error})), 32'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: actual kind %0d, required none", mon_kind);
      end else begin
        mon_ev = exp_q.pop_front();
        check("strobe_kind", {30'b0, mon_kind}, {30'b0, mon_ev.kind});
        check("strobe_frame_data", frame_data, mon_ev.data);
      end
    end
  end

  function automatic int jit(input int c, input int r);
    return c - r + int'($urandom_range(2 * r));
  endfunction

  task automatic level(input logic lvl, input int ticks);
    ir = lvl;
    repeat (ticks * TD) @(negedge clk);
  endtask

  task automatic drive_lead(input logic rpt);
    level(1'b0, jit(900, 20));
    if (rpt) level(1'b1, jit(225, 5));
    else     level(1'b1, jit(450, 10));
  endtask

  task automatic drive_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      level(1'b0, jit(56, 5));
      if (w[i]) level(1'b1, jit(169, 8));
      else      level(1'b1, jit(56, 5));
    end
  endtask

  task automatic send_frame(input logic [31:0] w);
    if (w[31:24] == ~w[23:16]) begin
      exp_q.push_back({K_VALID, w});
      m_data = w;
      m_have = 1'b1;
    end else begin
      exp_q.push_back({K_ERR, m_data});
      m_have = 1'b0;
    end
    drive_lead(1'b0);
    drive_bits(w, 32);
    level(1'b0, jit(56, 5));
    level(1'b1, 200);
  endtask

  task automatic send_repeat();
    if (m_have) exp_q.push_back({K_RPT, m_data});
    drive_lead(1'b1);
    level(1'b0, jit(56, 5));
    level(1'b1, 200);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ir  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_frame_data", frame_data, 32'h0);
    check("reset_strobes", {29'b0, frame_valid, frame_repeat, frame_error}, 32'h0);
    rst = 1'b0;
    m_data = '0;
    m_have = 1'b0;
    exp_q.delete();
    level(1'b1, 20);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check({"drain_", name}, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] nec_word(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  initial begin
    logic [31:0] w;

    // Reset with the line toggling: everything must sit at zero.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ir = ~ir;
    end
    check("rst_frame_data", frame_data, 32'h0);
    check("rst_valid", {31'b0, frame_valid}, 32'h0);
    check("rst_repeat", {31'b0, frame_repeat}, 32'h0);
    check("rst_error", {31'b0, frame_error}, 32'h0);
    ir  = 1'b1;
    rst = 1'b0;
    level(1'b1, 2000);
    wait_drain("idle");

    // Reference frame addr 0x04 cmd 0x08.
    send_frame(32'hF708FB04);
    wait_drain("frame1");
    check("frame1_data", frame_data, 32'hF708FB04);

    send_repeat();
    wait_drain("repeat1");
    check("repeat1_data", frame_data, 32'hF708FB04);

    // Repeat with no frame since reset is ignored.
    do_reset();
    send_repeat();
    wait_drain("repeat_after_reset");

    // Checksum failure keeps frame_data and disarms repeats.
    send_frame(nec_word(8'h04, 8'h08));
    wait_drain("frame2");
    send_frame({8'h00, 8'h08, 8'hFB, 8'h04});
    wait_drain("checksum_fail");
    check("checksum_fail_data", frame_data, 32'hF708FB04);
    send_repeat();
    wait_drain("repeat_after_error");

    // Short glitch must not start a frame; a stuck FSM would time out here.
    ir = 1'b0;
    repeat (3) @(negedge clk);
    level(1'b1, 1500);
    wait_drain("glitch");

    // Truncated frame: 10 bits then the line stays high past the timeout.
    w = nec_word(8'($urandom), 8'($urandom));
    exp_q.push_back({K_ERR, m_data});
    m_have = 1'b0;
    drive_lead(1'b0);
    drive_bits(w, 10);
    level(1'b1, 1500);
    wait_drain("timeout");
    w = nec_word(8'($urandom), 8'($urandom));
    send_frame(w);
    wait_drain("after_timeout");

    // Reset during bit 15, then a full frame.
    drive_lead(1'b0);
    drive_bits(32'hA5A5_5A5A, 15);
    level(1'b0, 20);
    do_reset();
    send_frame(32'h00FFFF00);
    wait_drain("after_mid_reset");
    check("after_mid_reset_data", frame_data, 32'h00FFFF00);

    // Random frames, some with a corrupted inverse command byte.
    for (int k = 0; k < 2; k++) begin
      w = nec_word(8'($urandom), 8'($urandom));
      if ($urandom_range(1) == 1) w[31:24] = w[31:24] ^ 8'($urandom_range(1, 255));
      send_frame(w);
      send_repeat();
      wait_drain("random");
    end

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
